sm_fetch_unit: RTL and testbench



---
 rtl/sm_fetch_unit_pkg.sv | 24 ++
 rtl/sm_fetch_fifo.sv | 64 ++++++
 rtl/sm_fetch_unit.sv | 135 +++++++++++++
 tb/tb_sm_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sm_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: word type, FSM states and the
// prefetch buffer entry layout.
package sm_fetch_unit_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic {
    FS_FETCH   = 1'b0,
    FS_DISCARD = 1'b1
  } fetchState_e;

  // Buffer entry is {pc, instr}, pc in the upper half.
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetchEntry_t;

  function automatic word_t nextWordAddr(input word_t addr);
    return addr + word_t'(1);
  endfunction

endpackage

// File: rtl/sm_fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries with flush; the head entry
// is presented straight from the storage registers.
module sm_fetch_fifo
  import sm_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetchEntry_t            pushData,
  output fetchEntry_t            head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  fetchEntry_t           storage [DEPTH];
  logic [PtrW-1:0]       wrPtr;
  logic [PtrW-1:0]       rdPtr;
  logic                  full;
  logic                  doPush;
  logic                  doPop;

  assign empty  = (count == '0);
  assign full   = (count == CntW'(DEPTH));
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign head   = storage[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      // NOTE: storage is reset on purpose -- the head feeds instr/instr_pc
      // directly and those must read zero after reset. A plain data buffer
      // would normally leave its array unreset.
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      // NOTE: every register here uses <= so all updates see pre-edge values;
      // a blocking = would let the count update leak into later statements.
      if (doPush) begin
        storage[wrPtr] <= pushData;
        wrPtr          <= wrPtr + PtrW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      count <= count + CntW'(doPush) - CntW'(doPop);
    end
  end

endmodule

// File: rtl/sm_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues req/ack word reads to
// instruction memory and buffers returned words for the core.
module sm_fetch_unit
  import sm_fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CntW = $clog2(DEPTH) + 1;

  fetchState_e     state, stateNext;
  logic            memReq, memReqNext;
  word_t           memAddr, memAddrNext;
  word_t           fetchPc, fetchPcNext;
  word_t           targetPc, targetPcNext;

  logic            xfer;
  logic            popOk;
  logic            fifoPush, fifoPop, fifoFlush;
  logic [CntW-1:0] fifoCount;
  logic [CntW-1:0] countNext;
  logic            fifoEmpty;
  fetchEntry_t     pushEntry;
  fetchEntry_t     headEntry;

  assign xfer      = memReq & mem_ack;
  assign popOk     = ~fifoEmpty & instr_ready;
  assign pushEntry = '{pc: memAddr, instr: mem_rdata};

  sm_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifoPush),
    .pop      (fifoPop),
    .flush    (fifoFlush),
    .pushData (pushEntry),
    .head     (headEntry),
    .count    (fifoCount),
    .empty    (fifoEmpty)
  );

  assign instr_valid = ~fifoEmpty;
  assign instr       = headEntry.instr;
  assign instr_pc    = headEntry.pc;
  assign mem_req     = memReq;
  assign mem_addr    = memAddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FS_FETCH;
      memReq   <= 1'b0;
      memAddr  <= '0;
      fetchPc  <= RESET_PC;
      targetPc <= '0;
    end else begin
      state    <= stateNext;
      memReq   <= memReqNext;
      memAddr  <= memAddrNext;
      fetchPc  <= fetchPcNext;
      targetPc <= targetPcNext;
    end
  end

  // fetchPc is the next address to request; it equals memAddr while a
  // request is pending, so a held request keeps a stable address.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    stateNext    = state;
    memReqNext   = memReq;
    memAddrNext  = memAddr;
    fetchPcNext  = fetchPc;
    targetPcNext = targetPc;
    fifoPush     = 1'b0;
    fifoPop      = 1'b0;
    fifoFlush    = 1'b0;
    countNext    = fifoCount;

    if (redirect) begin
      fifoFlush = 1'b1;
      if (memReq && !mem_ack) begin
        // Old request still in flight: hold it, remember the newest target.
        stateNext    = FS_DISCARD;
        targetPcNext = redirect_pc;
      end else begin
        stateNext   = FS_FETCH;
        fetchPcNext = redirect_pc;
        memReqNext  = 1'b1;
        memAddrNext = redirect_pc;
      end
    end else begin
      unique case (state)
        FS_FETCH: begin
          fifoPush  = xfer;
          fifoPop   = popOk;
          countNext = fifoCount + CntW'(xfer) - CntW'(popOk);
          if (xfer) begin
            fetchPcNext = nextWordAddr(memAddr);
          end
          // A pending request owns one slot, so only request when one is free.
          memReqNext = (countNext < CntW'(DEPTH));
          if (memReqNext) begin
            memAddrNext = fetchPcNext;
          end
        end
        FS_DISCARD: begin
          if (xfer) begin
            stateNext   = FS_FETCH;
            fetchPcNext = targetPc;
            memReqNext  = 1'b1;
            memAddrNext = targetPc;
          end
        end
        default: stateNext = FS_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_fetch_unit.sv
// Self-checking bench for sm_fetch_unit: directed scenarios plus randomized
// traffic, all compared every cycle against a queue-based reference model.
module tb_sm_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  sm_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  // Reference model: buffered words, pending request, discard bookkeeping.
  entry_t      mq[$];
  bit          mReq;
  logic [31:0] mPc;
  bit          mDisc;
  logic [31:0] mTarget;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'hA5A50F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit rd, input logic [31:0] rpc,
                           input bit rdy, input bit ack);
    bit xfer;
    bit pop;
    if (r) begin
      mq.delete();
      mReq    = 1'b0;
      mPc     = RESET_PC;
      mDisc   = 1'b0;
      mTarget = '0;
      return;
    end
    xfer = mReq && ack;
    pop  = (mq.size() > 0) && rdy;
    if (rd) begin
      mq.delete();
      if (mReq && !xfer) begin
        mDisc   = 1'b1;
        mTarget = rpc;
      end else begin
        mDisc = 1'b0;
        mReq  = 1'b1;
        mPc   = rpc;
      end
    end else if (mDisc) begin
      if (xfer) begin
        mDisc = 1'b0;
        mPc   = mTarget;
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (xfer) begin
        mq.push_back('{pc: mPc, data: memWord(mPc)});
        mPc = mPc + 32'd1;
      end
      mReq = (mq.size() < DEPTH);
    end
  endtask

  task automatic compare(input bit inReset);
    check("mem_req", 32'(mem_req), 32'(mReq));
    if (mReq) check("mem_addr", mem_addr, mPc);
    check("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("instr_pc", instr_pc, mq[0].pc);
      check("instr", instr, mq[0].data);
    end
    if (inReset) begin
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
    end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cycle(input bit r, input bit rd, input logic [31:0] rpc,
                       input bit rdy, input bit ack);
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
    mem_ack     = ack;
    mem_rdata   = mReq ? memWord(mPc) : $urandom();
    modelStep(r, rd, rpc, rdy, ack);
    @(posedge clk);
    #1;
    compare(r);
  endtask

  initial begin
    logic [31:0] rpc;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    mReq        = 1'b0;
    mPc         = RESET_PC;
    mDisc       = 1'b0;
    mTarget     = '0;

    // Reset, then zero-wait streaming.
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Backpressure until full, single pop, refill.
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("full_no_req", 32'(mem_req), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Redirect with nothing outstanding (FIFO full, no request).
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
    check("redir_flush", 32'(instr_valid), 32'h0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect during a slow request.
    cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("discard_target", mem_addr, 32'h100);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Double redirect while discarding.
    cycle(1'b0, 1'b1, 32'h20, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h30, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("double_target", mem_addr, 32'h30);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Address wrap, then redirect colliding with a pop.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                        : $urandom();
      cycle($urandom_range(0, 499) == 0,
            $urandom_range(0, 19) == 0,
            rpc,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
